// File: rtl/ltl_report_pkg.sv
// ltl_report_pkg
// Shared constants, the default event record and a saturating-increment helper
// for the automaton report collector.
//   NUM_REPORTS_DEF : report wires per automaton cluster
//   OFFSET_W_DEF    : symbol offset width
//   DEPTH_DEF       : event FIFO entries (power of two, >= 2)
//   DROP_W_DEF      : dropped-event counter width (<= 64)
package ltl_report_pkg;

    localparam int NUM_REPORTS_DEF = 4;
    localparam int OFFSET_W_DEF    = 32;
    localparam int DEPTH_DEF       = 8;
    localparam int DROP_W_DEF      = 16;

    // Event record at the default widths. Instances with other widths declare
    // an identically shaped local struct and hand it to the FIFO as a type.
    typedef struct packed {
        logic [OFFSET_W_DEF-1:0]    offset;
        logic [NUM_REPORTS_DEF-1:0] vector;
    } report_event_t;

    // Increment that sticks at max_val; callers zero-extend into 64 bits.
    function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                            input logic [63:0] max_val);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// ltl_report_fifo
// First-word-fall-through synchronous FIFO of event records.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : write wr_data; accepted when not full, or when full and a pop
//                happens in the same cycle
//   pop        : retire the head entry (ignored when empty)
//   wr_data    : entry to write
//   rd_data    : head entry, valid while empty=0
//   full/empty : derived from level
//   level      : current occupancy, 0..DEPTH
module ltl_report_fifo
    import ltl_report_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = report_event_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wr_data,
    output T                       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W+1)'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == DEPTH_LVL);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // A pop frees the slot the push needs, so full+pop still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (PTR_W+1)'(1);
                2'b01:   level_q <= level_q - (PTR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ltl_report_collector.sv
// ltl_report_collector
// Turns sampled automaton report wires into (offset, vector) events, buffers
// them in a FWFT FIFO and drains them over valid/ready. Keeps a sticky overflow
// flag and a saturating dropped-event counter.
//   clk, reset   : clock, synchronous active-high reset
//   sample       : report wires reflect a newly consumed symbol this cycle
//   reports      : report wires, bit i = report i
//   clear_stats  : pulse; clears overflow and drop_count
//   out_valid    : head event available
//   out_ready    : consumer accepts the head event
//   out_offset   : symbol offset of the head event
//   out_vector   : report vector of the head event
//   overflow     : sticky, an event was dropped on a full FIFO
//   drop_count   : saturating count of dropped events
//   level        : FIFO occupancy
module ltl_report_collector
    import ltl_report_pkg::*;
#(
    parameter int NUM_REPORTS = NUM_REPORTS_DEF,
    parameter int OFFSET_W    = OFFSET_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int DROP_W      = DROP_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample,
    input  logic [NUM_REPORTS-1:0] reports,
    input  logic                   clear_stats,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OFFSET_W-1:0]    out_offset,
    output logic [NUM_REPORTS-1:0] out_vector,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic [$clog2(DEPTH):0] level
);

    typedef struct packed {
        logic [OFFSET_W-1:0]    offset;
        logic [NUM_REPORTS-1:0] vector;
    } event_t;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic   push;
    logic   pop;
    logic   drop;
    logic   fifo_full;
    logic   fifo_empty;
    event_t wr_event;
    event_t head_event;

    assign push      = sample && (|reports);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && fifo_full && !pop;

    // The event carries the offset before this cycle's increment.
    assign wr_event.offset = offset_q;
    assign wr_event.vector = reports;

    ltl_report_fifo #(
        .DEPTH (DEPTH),
        .T     (event_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_event),
        .rd_data (head_event),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Gate the head so the outputs read zero rather than stale memory when empty.
    assign out_offset = out_valid ? head_event.offset : '0;
    assign out_vector = out_valid ? head_event.vector : '0;

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    // Clear is applied before the drop of the same cycle is counted.
    always_comb begin
        offset_d   = offset_q + (sample ? OFFSET_W'(1) : OFFSET_W'(0));
        overflow_d = clear_stats ? 1'b0 : overflow_q;
        drop_d     = clear_stats ? '0 : drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = DROP_W'(sat_inc(64'(drop_d), 64'(DROP_MAX)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            offset_q   <= offset_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Sits directly downstream of a monitor automaton; captures its report wires, for example the four report outputs of a cluster.
- Each sampled cycle with at least one active report becomes an event: report vector plus the symbol offset at which it fired.
- Events are buffered in a small FIFO and drained over a valid/ready interface toward the monitor aggregation / CSR logic.
- Tracks overflow and dropped-event statistics.

Parameters:
- NUM_REPORTS, 4, number of automaton report wires collected
- OFFSET_W, 32, width of the symbol offset counter and of the offset field in each event
- DEPTH, 8, FIFO entries; power of two, minimum 2
- DROP_W, 16, width of the saturating dropped-event counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- sample  input  1  report wires reflect a newly consumed symbol this cycle
- reports  input  NUM_REPORTS  automaton active_state report wires; bit i = report i
- clear_stats  input  1  one-cycle pulse; clears overflow and drop_count only
- out_valid  output  1  head event available
- out_ready  input  1  consumer accepts the head event
- out_offset  output  OFFSET_W  symbol offset of the head event
- out_vector  output  NUM_REPORTS  report vector of the head event
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- drop_count  output  DROP_W  saturating count of dropped events
- level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - out_valid=0, out_offset=0, out_vector=0, overflow=0, drop_count=0, level=0.
  - Offset counter = 0; FIFO empty.
- Offset counter:
  - Increments by 1 on every cycle with sample=1, whether or not a report fired.
  - The event captured in a cycle carries the counter value before that increment, so the first sampled symbol has offset 0.
  - Wraps modulo 2^OFFSET_W silently.
- Push condition: sample=1 and |reports=1. Cycles with sample=0 are ignored even if reports is non-zero.
- FIFO:
  - First-word-fall-through.
  - out_valid = (level != 0).
  - out_offset/out_vector show the head entry and hold stable while out_valid=1 and out_ready=0.
  - Pop occurs when out_valid and out_ready are both 1.
- Latency: an event pushed in cycle N is visible on the outputs in cycle N+1 when the FIFO was empty.
- Push while not full: the entry is written and level increments, unless there is a simultaneous pop, in which case level is unchanged.
- Push while full without pop: the event is dropped.
  - overflow is set to 1.
  - drop_count increments, saturating at 2^DROP_W-1.
  - FIFO contents and level are unchanged.
- Push while full with simultaneous pop: the push is accepted and level stays DEPTH. No drop.
- Pop with no push when the FIFO is empty: impossible, since out_valid=0.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from level.
- clear_stats:
  - Clears overflow and drop_count on the next edge.
  - If a drop occurs in the same cycle, the result is overflow=1 and drop_count=1 (clear applied first, then the drop counted).
  - Does not affect the FIFO or the offset counter.
- Reset mid-operation: empties the FIFO, zeroes the offset and all statistics in one cycle, and discards any in-flight event. Inputs in the reset cycle are ignored.
- out_ready may be asserted while out_valid=0; it has no effect.

Decomposition:
- Package ltl_report_pkg:
  - Default constants for NUM_REPORTS, OFFSET_W, DEPTH, DROP_W.
  - Packed struct report_event_t {offset, vector}, parameterised by those constants.
  - Helper function for saturating increment.
- Sub-module ltl_report_fifo: generic FWFT synchronous FIFO of report_event_t, providing push/pop/full/empty/level.
- The top-level module holds the offset counter, push qualification, drop/overflow statistics and the clear_stats handling.

Test Plan:
- Reset, then sample=1 with reports=0 for 3 cycles, then reports=4'b0100 with sample=1 -> out_valid=1 the next cycle with out_offset=3, out_vector=4'b0100, level=1.
- reports=4'b1001 held with sample=0 for 5 cycles -> no event, offset counter unchanged, out_valid=0.
- out_ready=0, and 10 consecutive sampled cycles each with reports=4'b0001 (DEPTH=8) -> level=8, overflow=1, drop_count=2; draining yields offsets 0..7 in order.
- FIFO full and out_ready=1 with a push in the same cycle -> level stays 8, drop_count unchanged, the new entry appears last on drain.
- clear_stats pulsed in the same cycle as a drop -> overflow=1, drop_count=1; clear_stats alone afterwards -> overflow=0, drop_count=0, FIFO untouched.
- OFFSET_W=4, 17 sampled cycles with a report on the 17th -> out_offset=0 (wrap). Reset asserted with 3 entries queued -> level=0, out_valid=0 the next cycle, and the next event has offset 0.
